spectrum_peak_detect: RTL and testbench

Downstream consumer of the FFT magnitude stage. Scans one frame of magnitude bins (`mag_valid`/`mag_addr`/`mag_in`) over a configurable bin window and reports the largest bin, its index and the window magnitude sum once per frame. The results feed the display/measurement logic: fundamental-frequency readout and an SNR-style power estimate.

---
 rtl/spectrum_peak_detect.sv | 120 ++++++++++++
 tb/tb_spectrum_peak_detect.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_detect.sv
// Per-frame peak search over FFT magnitude bins: reports the largest in-window bin,
// its index and the window magnitude sum once per completed frame.
module spectrum_peak_detect #(
  parameter int SKIP_LOW  = 4,
  parameter int SCAN_LAST = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] mag_in,
  input  logic [12:0] mag_addr,
  input  logic        mag_valid,
  output logic [15:0] peak_mag,
  output logic [12:0] peak_bin,
  output logic [27:0] mag_sum,
  output logic        result_valid,
  output logic [15:0] frame_cnt,
  output logic [7:0]  abort_cnt,
  output logic        busy
);

  localparam logic [12:0] L_SKIP = 13'(SKIP_LOW);
  localparam logic [12:0] L_LAST = 13'(SCAN_LAST);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

  state_t      r_state;
  logic [15:0] r_run_peak;
  logic [12:0] r_run_bin;
  logic [27:0] r_run_sum;
  logic [15:0] r_peak_mag;
  logic [12:0] r_peak_bin;
  logic [27:0] r_mag_sum;
  logic        r_result_valid;
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_abort_cnt;

  logic        w_addr0;
  logic        w_start;
  logic        w_abort;
  logic        w_take;
  logic        w_in_win;
  logic        w_upd;
  logic [15:0] w_base_peak;
  logic [12:0] w_base_bin;
  logic [27:0] w_base_sum;
  logic [15:0] w_next_peak;
  logic [12:0] w_next_bin;
  logic [27:0] w_next_sum;

  // A start sample (fresh or abort-restart) is evaluated against cleared running
  // values, so the start bin itself can win when SKIP_LOW is 0.
  always_comb begin
    w_addr0     = mag_valid && (mag_addr == 13'd0);
    w_start     = w_addr0 && (((r_state == S_IDLE) && enable) || (r_state == S_SCAN));
    w_abort     = w_addr0 && (r_state == S_SCAN);
    w_take      = mag_valid && ((r_state == S_SCAN) || w_start);
    w_in_win    = (mag_addr >= L_SKIP) && (mag_addr <= L_LAST);
    w_base_peak = w_start ? 16'd0 : r_run_peak;
    w_base_bin  = w_start ? L_SKIP : r_run_bin;
    w_base_sum  = w_start ? 28'd0 : r_run_sum;
    w_upd       = w_in_win && (mag_in > w_base_peak);
    w_next_peak = w_upd ? mag_in : w_base_peak;
    w_next_bin  = w_upd ? mag_addr : w_base_bin;
    w_next_sum  = w_base_sum + (w_in_win ? {12'd0, mag_in} : 28'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_run_peak     <= '0;
      r_run_bin      <= '0;
      r_run_sum      <= '0;
      r_peak_mag     <= '0;
      r_peak_bin     <= '0;
      r_mag_sum      <= '0;
      r_result_valid <= 1'b0;
      r_frame_cnt    <= '0;
      r_abort_cnt    <= '0;
    end else begin
      // NOTE: non-blocking everywhere here; the default below makes result_valid a one-cycle pulse.
      r_result_valid <= 1'b0;
      if (w_take) begin
        r_run_peak <= w_next_peak;
        r_run_bin  <= w_next_bin;
        r_run_sum  <= w_next_sum;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (w_abort) begin
            if (r_abort_cnt != 8'hFF) r_abort_cnt <= r_abort_cnt + 8'd1;
          end else if (mag_valid && (mag_addr == L_LAST)) begin
            r_state <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_peak_mag     <= r_run_peak;
          r_peak_bin     <= r_run_bin;
          r_mag_sum      <= r_run_sum;
          r_result_valid <= 1'b1;
          r_frame_cnt    <= r_frame_cnt + 16'd1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign peak_mag     = r_peak_mag;
  assign peak_bin     = r_peak_bin;
  assign mag_sum      = r_mag_sum;
  assign result_valid = r_result_valid;
  assign frame_cnt    = r_frame_cnt;
  assign abort_cnt    = r_abort_cnt;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_spectrum_peak_detect.sv
// Self-checking bench for spectrum_peak_detect: table-driven frames with a result
// scoreboard, plus hand-written abort, enable, REPORT-ignore and reset sequences.
module tb_spectrum_peak_detect;

  localparam int SKIP_LOW  = 4;
  localparam int SCAN_LAST = 4095;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] mag_in;
  logic [12:0] mag_addr;
  logic        mag_valid;
  logic [15:0] peak_mag;
  logic [12:0] peak_bin;
  logic [27:0] mag_sum;
  logic        result_valid;
  logic [15:0] frame_cnt;
  logic [7:0]  abort_cnt;
  logic        busy;

  spectrum_peak_detect #(.SKIP_LOW(SKIP_LOW), .SCAN_LAST(SCAN_LAST)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mag_in(mag_in), .mag_addr(mag_addr),
    .mag_valid(mag_valid), .peak_mag(peak_mag), .peak_bin(peak_bin), .mag_sum(mag_sum),
    .result_valid(result_valid), .frame_cnt(frame_cnt), .abort_cnt(abort_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    int          t1b;
    logic [15:0] t1v;
    int          t2b;
    logic [15:0] t2v;
    int          last;
    bit          gaps;
    logic [15:0] e_peak;
    logic [12:0] e_bin;
    logic [27:0] e_sum;
  } vec_t;

  typedef struct packed {
    logic [15:0] p;
    logic [12:0] b;
    logic [27:0] s;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rv_pulses = 0;
  int   post = 0;
  int   exp_frames = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bin_val(input vec_t v, input int a);
    if (a == v.t1b) return v.t1v;
    if (a == v.t2b) return v.t2v;
    return v.base;
  endfunction

  // Scoreboard: every result pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    res_t e;
    if (!rst && result_valid) begin
      rv_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("peak_mag", 64'(peak_mag), 64'(e.p));
        check("peak_bin", 64'(peak_bin), 64'(e.b));
        check("mag_sum",  64'(mag_sum),  64'(e.s));
      end
    end
  end

  // One cycle of stimulus; also checks busy/result_valid timing after an armed last bin.
  task automatic tick(input logic v, input logic [12:0] a, input logic [15:0] d, input bit arm);
    @(negedge clk);
    if (post != 0) begin
      case (post)
        1: begin check("busy_after_last", 64'(busy), 64'd1); check("rv_early", 64'(result_valid), 64'd0); end
        2: begin check("busy_fall", 64'(busy), 64'd0); check("rv_pulse", 64'(result_valid), 64'd1); end
        default: check("rv_width", 64'(result_valid), 64'd0);
      endcase
      post = (post == 3) ? 0 : post + 1;
    end
    mag_valid = v;
    mag_addr  = a;
    mag_in    = d;
    if (v && arm && (a == 13'(SCAN_LAST))) post = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 13'd0, 16'd0, 1'b0);
  endtask

  task automatic run_frame(input vec_t v, input int drop_at, input bit arm);
    for (int a = 0; a <= v.last; a++) begin
      if (v.gaps && a <= SCAN_LAST)
        while ($urandom_range(0, 3) == 0) tick(1'b0, 13'($urandom), 16'($urandom), 1'b0);
      if (a == drop_at) enable = 1'b0;
      tick(1'b1, 13'(a), bin_val(v, a), arm);
    end
  endtask

  task automatic push_exp(input logic [15:0] p, input logic [12:0] b, input logic [27:0] s);
    exp_q.push_back({p, b, s});
    exp_frames++;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   fc0;
    int   rv0;
    vec_t pv;

    //          base   t1b   t1v    t2b  t2v   last  gaps peak   bin   sum
    vecs[0] = '{16'd100,   1000, 16'd5000,  -1,   16'd0,    8191, 1'b0, 16'd5000,  13'd1000, 28'd414100};
    vecs[1] = '{16'd0,     2,    16'd60000, 300,  16'd2000, 4095, 1'b0, 16'd2000,  13'd300,  28'd2000};
    vecs[2] = '{16'd0,     500,  16'd3000,  700,  16'd3000, 4095, 1'b0, 16'd3000,  13'd500,  28'd6000};
    vecs[3] = '{16'd65535, -1,   16'd0,     -1,   16'd0,    4095, 1'b0, 16'd65535, 13'd4,    28'd268169220};
    vecs[4] = '{16'd0,     -1,   16'd0,     -1,   16'd0,    4095, 1'b0, 16'd0,     13'd4,    28'd0};
    vecs[5] = '{16'd100,   1000, 16'd5000,  -1,   16'd0,    4095, 1'b1, 16'd5000,  13'd1000, 28'd414100};
    vecs[6] = '{16'd1,     4,    16'd50,    4095, 16'd60,   4095, 1'b0, 16'd60,    13'd4095, 28'd4200};

    rst = 1'b1; enable = 1'b1; mag_valid = 1'b0; mag_addr = '0; mag_in = '0;
    repeat (3) @(negedge clk);
    check("rst_peak_mag", 64'(peak_mag), 64'd0);
    check("rst_peak_bin", 64'(peak_bin), 64'd0);
    check("rst_mag_sum",  64'(mag_sum),  64'd0);
    check("rst_rv",       64'(result_valid), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_abort_cnt", 64'(abort_cnt), 64'd0);
    check("rst_busy",     64'(busy), 64'd0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 7; i++) begin
      rv0 = rv_pulses;
      push_exp(vecs[i].e_peak, vecs[i].e_bin, vecs[i].e_sum);
      run_frame(vecs[i], -1, 1'b1);
      idle(4);
      check($sformatf("frame_cnt_v%0d", i), 64'(frame_cnt), 64'(exp_frames));
      check($sformatf("pulses_v%0d", i), 64'(rv_pulses - rv0), 64'd1);
    end

    // Abort: partial frame with a huge bin, then a clean frame.
    rv0 = rv_pulses;
    pv = '{16'd50, 1000, 16'd60000, -1, 16'd0, 2000, 1'b0, 16'd0, 13'd0, 28'd0};
    run_frame(pv, -1, 1'b0);
    pv = '{16'd7, 1500, 16'd9000, -1, 16'd0, 4095, 1'b0, 16'd0, 13'd0, 28'd0};
    push_exp(16'd9000, 13'd1500, 28'd37637);
    run_frame(pv, -1, 1'b1);
    idle(4);
    check("abort_cnt_one", 64'(abort_cnt), 64'd1);
    check("abort_pulses", 64'(rv_pulses - rv0), 64'd1);

    // Saturating aborts, then a one-sample close and an addr-0 arriving in REPORT.
    tick(1'b1, 13'd0, 16'd111, 1'b0);
    for (int i = 0; i < 300; i++) tick(1'b1, 13'd0, 16'd222, 1'b0);
    check("abort_sat", 64'(abort_cnt), 64'd255);
    push_exp(16'd777, 13'(SCAN_LAST), 28'd777);
    tick(1'b1, 13'(SCAN_LAST), 16'd777, 1'b1);
    tick(1'b1, 13'd0, 16'd999, 1'b0);
    idle(4);
    check("report_ignores_addr0", 64'(busy), 64'd0);
    check("abort_sat_hold", 64'(abort_cnt), 64'd255);
    check("frame_cnt_sat_seq", 64'(frame_cnt), 64'(exp_frames));

    // enable low at addr 0: no scan at all.
    fc0 = frame_cnt; rv0 = rv_pulses;
    enable = 1'b0;
    tick(1'b1, 13'd0, 16'd100, 1'b0);
    tick(1'b0, 13'd0, 16'd0, 1'b0);
    check("no_scan_busy", 64'(busy), 64'd0);
    run_frame(vecs[0], -1, 1'b0);
    idle(4);
    check("no_scan_busy_end", 64'(busy), 64'd0);
    check("no_scan_frames", 64'(frame_cnt), 64'(fc0));
    check("no_scan_pulses", 64'(rv_pulses - rv0), 64'd0);
    enable = 1'b1;

    // enable dropped mid-scan: frame completes.
    rv0 = rv_pulses;
    push_exp(vecs[2].e_peak, vecs[2].e_bin, vecs[2].e_sum);
    run_frame(vecs[2], 100, 1'b1);
    idle(4);
    enable = 1'b1;
    check("en_drop_frames", 64'(frame_cnt), 64'(exp_frames));
    check("en_drop_pulses", 64'(rv_pulses - rv0), 64'd1);

    // Reset mid-scan at bin 3000.
    pv = vecs[0];
    pv.last = 3000;
    run_frame(pv, -1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_peak_mag", 64'(peak_mag), 64'd0);
    check("mid_rst_peak_bin", 64'(peak_bin), 64'd0);
    check("mid_rst_mag_sum",  64'(mag_sum),  64'd0);
    check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("mid_rst_abort_cnt", 64'(abort_cnt), 64'd0);
    check("mid_rst_busy",     64'(busy), 64'd0);
    idle(2);
    rst = 1'b0;
    exp_frames = 0;
    idle(2);
    push_exp(vecs[6].e_peak, vecs[6].e_bin, vecs[6].e_sum);
    run_frame(vecs[6], -1, 1'b1);
    idle(4);
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);
    check("post_rst_abort_cnt", 64'(abort_cnt), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
